// File: rtl/booth_product_accumulator.sv
// Block accumulator behind the radix-8 Booth multiplier: sums up to ACC_LEN signed
// products, then hands the block sum out over valid/ready. BOOTH_ACC_SAT_EN selects saturation.
module booth_product_accumulator #(
    parameter int N       = 32,
    parameter int PW      = 2 * N,
    parameter int G       = 8,
    parameter int ACC_LEN = 16,
    localparam int ACC_W  = PW + G,
    localparam int CW     = $clog2(ACC_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CW-1:0]    out_count,
    output logic             out_ovf
);

    typedef enum logic {S_ACC, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [CW-1:0]     out_count_q, out_count_d;

    logic [ACC_W-1:0]  addend, sum_raw, sum;
    logic              take, close, drain;

    assign in_ready = rst & (state_q == S_ACC);

    // clr beats both the accept and the handoff, so gate them here once
    assign take  = ~clr & in_valid & in_ready;
    assign close = take & (in_last | (cnt_q == CW'(ACC_LEN - 1)));
    assign drain = ~clr & (state_q == S_HOLD) & out_valid_q & out_ready;

`ifdef BOOTH_ACC_SAT_EN
    logic ovf_add;
    logic ovf_q, ovf_d;
    logic out_ovf_q, out_ovf_d;
`endif

    always_comb begin
        addend  = ACC_W'($signed(in_product));
        sum_raw = acc_q + addend;
`ifdef BOOTH_ACC_SAT_EN
        ovf_add = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum_raw[ACC_W-1] != addend[ACC_W-1]);
        if (ovf_add)
            sum = addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum = sum_raw;
`else
        sum = sum_raw;
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        if (clr) begin
            state_d     = S_ACC;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (take) begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
            if (close) begin
                state_d     = S_HOLD;
                out_valid_d = 1'b1;
                out_acc_d   = sum;
                out_count_d = cnt_q + CW'(1);
            end
        end else if (drain) begin
            state_d     = S_ACC;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
        end
    end

`ifdef BOOTH_ACC_SAT_EN
    // sticky per block; snapshotted into out_ovf on the closing beat
    always_comb begin
        ovf_d     = ovf_q;
        out_ovf_d = out_ovf_q;
        if (clr || drain) begin
            ovf_d = 1'b0;
        end else if (take) begin
            ovf_d = ovf_q | ovf_add;
            if (close)
                out_ovf_d = ovf_q | ovf_add;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q     <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;

endmodule
